// File: rtl/fs4_serial.sv
// fs4_serial -- bit-serial subtractor, D = A - B - BIn, one bit per clock, LSB first.
//
// A single registered borrow ripples through WIDTH cycles. A Start/Done handshake
// sequences each operation; D and BOut hold the last completed result.
//
// Optional build macro: FS4_FLAGS_EN adds registered zero / ovf result flags.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request an operation (sampled only while idle)
//   a, b   in   minuend / subtrahend, WIDTH bits, sampled on the accepting edge
//   bin    in   borrow-in, sampled on the accepting edge
//   busy   out  operation in progress
//   done   out  one-cycle pulse when d / bout update
//   d      out  difference of the last completed operation
//   zero   out  (FS4_FLAGS_EN) last completed d == 0
//   ovf    out  (FS4_FLAGS_EN) two's-complement overflow of the last operation
//   bout   out  borrow-out of the last completed operation
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the previous value
// RUN   | one difference bit produced per clock, WIDTH clocks total

module fs4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef FS4_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] a_sh, a_sh_n;
  logic [WIDTH-1:0] b_sh, b_sh_n;
  logic [WIDTH-1:0] r_sh, r_sh_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic             bw, bw_n;
  logic             done_q, done_n;
  logic             bout_q, bout_n;

  logic             dbit;
  logic             bw_calc;
  logic [WIDTH-1:0] r_cat;

`ifdef FS4_FLAGS_EN
  // Operand sign bits are kept aside because a_sh / b_sh are shifted away.
  logic a_msb, a_msb_n;
  logic b_msb, b_msb_n;
  logic zero_q, zero_n;
  logic ovf_q, ovf_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      d_q    <= '0;
      bw     <= 1'b0;
      done_q <= 1'b0;
      bout_q <= 1'b0;
`ifdef FS4_FLAGS_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      a_sh   <= a_sh_n;
      b_sh   <= b_sh_n;
      r_sh   <= r_sh_n;
      d_q    <= d_n;
      bw     <= bw_n;
      done_q <= done_n;
      bout_q <= bout_n;
`ifdef FS4_FLAGS_EN
      a_msb  <= a_msb_n;
      b_msb  <= b_msb_n;
      zero_q <= zero_n;
      ovf_q  <= ovf_n;
`endif
    end
  end

  always_comb begin
    dbit    = a_sh[0] ^ b_sh[0] ^ bw;
    bw_calc = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
    // New bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
    r_cat   = {dbit, r_sh[WIDTH-1:1]};

    state_n = state;
    cnt_n   = cnt;
    a_sh_n  = a_sh;
    b_sh_n  = b_sh;
    r_sh_n  = r_sh;
    d_n     = d_q;
    bw_n    = bw;
    done_n  = 1'b0;
    bout_n  = bout_q;
`ifdef FS4_FLAGS_EN
    a_msb_n = a_msb;
    b_msb_n = b_msb;
    zero_n  = zero_q;
    ovf_n   = ovf_q;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          a_sh_n  = a;
          b_sh_n  = b;
          bw_n    = bin;
          cnt_n   = '0;
          r_sh_n  = '0;
          state_n = RUN;
`ifdef FS4_FLAGS_EN
          a_msb_n = a[WIDTH-1];
          b_msb_n = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        bw_n   = bw_calc;
        r_sh_n = r_cat;
        a_sh_n = a_sh >> 1;
        b_sh_n = b_sh >> 1;
        cnt_n  = cnt + CW'(1);
        if (cnt == LAST) begin
          d_n     = r_cat;
          bout_n  = bw_calc;
          done_n  = 1'b1;
          state_n = IDLE;
`ifdef FS4_FLAGS_EN
          zero_n  = (r_cat == '0);
          ovf_n   = (a_msb ^ b_msb) & (r_cat[WIDTH-1] ^ a_msb);
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
`ifdef FS4_FLAGS_EN
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_fs4_serial.sv
// Directed testbench for fs4_serial (WIDTH = 4). Expected values are hand-computed
// constants or derived from integer arithmetic on the operands.
module tb_fs4_serial;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef FS4_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  fs4_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
`ifdef FS4_FLAGS_EN
    .zero  (zero),
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; everything is driven and sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with fixed timing: accept on edge 0, Done exactly on edge W.
  task automatic run_op(input int av, input int bv, input int bi,
                        input int exp_d, input int exp_bo,
                        input int exp_z, input int exp_ov);
    a = W'(av); b = W'(bv); bin = bi[0]; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("done_after_accept", done, 0);
    for (int i = 1; i < W; i++) begin
      tick();
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
    end
    tick();
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("d", d, exp_d);
    chk("bout", bout, exp_bo);
`ifdef FS4_FLAGS_EN
    chk("zero", zero, exp_z);
    chk("ovf", ovf, exp_ov);
`else
    if (exp_z < 0 || exp_ov < 0) $display("note: negative flag expectation ignored");
`endif
    tick();
    chk("done_drop", done, 0);
    chk("busy_idle", busy, 0);
    chk("d_hold", d, exp_d);
  endtask

  initial begin
    int sa, sb, r, ed, ebo, eov, gap;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
`ifdef FS4_FLAGS_EN
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    tick();

    // basic and borrow cases
    run_op(7, 3, 0, 4, 0, 0, 0);
    run_op(3, 7, 0, 12, 1, 0, 0);
    run_op(0, 0, 1, 15, 1, 0, 0);

    // start during busy is ignored, d holds prior result (15) until done
    a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
    tick();                         // edge 0
    start = 1'b0;
    tick();                         // edge 1
    a = 4'd1; b = 4'd1; start = 1'b1;
    tick();                         // edge 2
    start = 1'b0;
    chk("ign_busy", busy, 1);
    chk("ign_d_hold2", d, 15);
    tick();                         // edge 3
    chk("ign_d_hold3", d, 15);
    chk("ign_done3", done, 0);
    tick();                         // edge 4
    chk("ign_done", done, 1);
    chk("ign_d", d, 7);
    chk("ign_bout", bout, 0);
    tick();
    chk("ign_not_queued_busy", busy, 0);
    chk("ign_not_queued_done", done, 0);

    // start held high: 5-5 then 10-4; second accepted in the Done cycle,
    // so Done pulses on edges 4 and 9 with four non-Done cycles between
    a = 4'd5; b = 4'd5; bin = 1'b0; start = 1'b1;
    tick();                         // edge 0
    a = 4'd10; b = 4'd4;
    for (int i = 1; i < W; i++) begin
      tick();
      chk("held_done_low1", done, 0);
    end
    tick();                         // edge 4
    chk("held_done1", done, 1);
    chk("held_d1", d, 0);
    chk("held_bout1", bout, 0);
`ifdef FS4_FLAGS_EN
    chk("held_zero1", zero, 1);
`endif
    tick();                         // edge 5 accepts second op
    chk("held_restart_busy", busy, 1);
    chk("held_restart_done", done, 0);
    start = 1'b0;
    for (int i = 1; i < W; i++) begin
      tick();
      chk("held_done_low2", done, 0);
    end
    tick();                         // edge 9
    chk("held_done2", done, 1);
    chk("held_d2", d, 6);
    chk("held_bout2", bout, 0);
`ifdef FS4_FLAGS_EN
    chk("held_zero2", zero, 0);
`endif
    tick();
    chk("held_done_drop", done, 0);

    // reset during the second RUN cycle
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();                         // edge 0
    start = 1'b0;
    tick();                         // edge 1
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_d", d, 0);
    chk("abort_bout", bout, 0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("abort_no_done", done, 0);
      chk("abort_no_busy", busy, 0);
    end
    run_op(6, 1, 0, 5, 0, 0, 0);

    // signed-overflow cases: -8 - 1 overflows, 5 - 5 is zero
    run_op(8, 1, 0, 7, 0, 0, 1);
    run_op(5, 5, 0, 0, 0, 1, 0);

    // all operand combinations with random idle gaps
    for (int bi = 0; bi < 2; bi++) begin
      for (int av = 0; av < 16; av++) begin
        for (int bv = 0; bv < 16; bv++) begin
          ed  = (av - bv - bi) & 15;
          ebo = (av < bv + bi) ? 1 : 0;
          sa  = (av > 7) ? av - 16 : av;
          sb  = (bv > 7) ? bv - 16 : bv;
          r   = sa - sb - bi;
          eov = (r < -8 || r > 7) ? 1 : 0;
          gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) tick();
          run_op(av, bv, bi, ed, ebo, (ed == 0) ? 1 : 0, eov);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
